lsu_bus_master: RTL
===================

Name: lsu_bus_master

Overview:
- Load/store initiator on the CPU side of the word-wide memory bus (we/addr/wd/rd).
- Takes RISC-V load/store requests from the core over a valid/ready handshake.
- Issues word-aligned bus accesses, extracts and extends sub-word load data, and performs read-modify-write for byte and halfword stores.
- Returns one response per request: load data or an error flag.

Parameters:
RD_LATENCY, 1, cycles from mem_addr (with mem_we=0) being driven to mem_rd being valid; legal range 1..4

Ports:
clk  input  1  system clock
rst  input  1  reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid&&req_ready
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response valid
resp_ready  input  1  response consumed when resp_valid&&resp_ready
resp_rdata  output  32  load result (0 for stores/errors)
resp_err  output  1  misaligned or illegal request
mem_we  output  1  bus write enable
mem_addr  output  32  bus address, bits[1:0] always 0
mem_wd  output  32  bus write data
mem_rd  input  32  bus read data

Behaviour:
- One clock; reset is synchronous and active-high.
- On rst: state IDLE, mem_we=0, mem_addr=0, mem_wd=0, resp_valid=0, resp_rdata=0, resp_err=0, all internal registers cleared.
- rst mid-operation aborts at once; no further bus write is issued.
- req_ready=1 only in IDLE (combinational from state). mem_we, mem_addr, mem_wd, resp_* are registered.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE on accept, latch request, then:
  - illegal/misaligned -> RESP with err=1, rdata=0; no bus access.
  - SW -> WR.
  - load, SB or SH -> RD.
- RD: mem_addr={addr[31:2],2'b00}, mem_we=0, held for one cycle; load a latency counter with RD_LATENCY-1, go to WAIT.
- WAIT: hold mem_addr. When the counter reaches 0, sample mem_rd.
  - load: select lane by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. Go to RESP.
  - SB/SH: merge the store lane into the sampled word; other bytes unchanged. Go to WR.
- WR: mem_we=1 for exactly one cycle.
  - mem_addr = aligned address.
  - mem_wd = req_wdata for SW, or the merged word for SB/SH.
  - Go to RESP; mem_we returns to 0 the next cycle.
- RESP: resp_valid=1 with rdata/err stable until resp_ready. On handshake: resp_valid=0 next cycle, go to IDLE. A new request can be accepted the cycle after.
- Outside WR, mem_we=0 always. mem_addr/mem_wd hold their last values when idle.
- Latency, accept to resp_valid, with L=RD_LATENCY:
  - SW: 2
  - loads: L+2
  - SB/SH: L+3
  - errors: 1
- Maximum one outstanding request; a request is never dropped while req_ready=0.

Test Plan:
- RD_LATENCY=1, mem word 0x8899AABB at 0x10. LB addr 0x13 -> mem_addr=0x10, resp_rdata=0xFFFFFF88, resp_valid 3 cycles after accept. LBU addr 0x13 -> 0x00000088. LH addr 0x12 -> 0xFFFF8899.
- SW addr 0x20, wdata 0xDEADBEEF -> one cycle with mem_we=1, mem_addr=0x20, mem_wd=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
- Word 0x11223344 at 0x30. SB addr 0x31, wdata 0x000000AB -> read 0x30, then write mem_wd=0x1122AB44. SH addr 0x32, wdata 0xCAFE -> mem_wd=0xCAFE3344.
- LW addr 0x42 and SH addr 0x41 -> resp_err=1, resp_rdata=0, mem_we never 1, mem_addr unchanged. funct3=011 -> resp_err=1.
- Hold resp_ready=0 for 5 cycles after an LW -> resp_valid and resp_rdata stable, req_ready=0; raise resp_ready -> IDLE next cycle.
- Assert rst in the WAIT cycle of an SB -> mem_we never asserted, all outputs 0 next cycle. Repeat the load tests with RD_LATENCY=3 -> LW latency 5.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store initiator for the word-wide memory bus: aligned accesses, sub-word
// load extraction/extension and read-modify-write for byte/halfword stores.
module lsu_bus_master #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t      state;
    state_t      next_state;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;
    logic [1:0]  cnt_q;

    logic        fire;
    logic        req_legal;
    logic        req_misaligned;
    logic        req_err;

    logic [4:0]  lane_sh;
    logic [31:0] rd_shifted;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] load_data;

    logic        mem_we_d;
    logic        resp_valid_d;
    logic        resp_err_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_wd_d;
    logic [31:0] resp_rdata_d;

    assign req_ready = (state == IDLE);
    assign fire      = req_valid && req_ready;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err = !req_legal || req_misaligned;
    end

    // Lane shift serves both load extraction and store merge.
    always_comb begin
        lane_sh    = {addr_lo_q, 3'b000};
        rd_shifted = mem_rd >> lane_sh;
        lane_mask  = f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merged     = (mem_rd & ~(lane_mask << lane_sh)) |
                     (({16'h0000, wdata_q} & lane_mask) << lane_sh);
        case (f3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_data = {24'h000000, rd_shifted[7:0]};
            3'b101:  load_data = {16'h0000, rd_shifted[15:0]};
            default: load_data = mem_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD:   next_state = WAIT;
            WAIT: begin
                if (cnt_q == '0) begin
                    next_state = we_q ? WR : RESP;
                end
            end
            WR:   next_state = RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state so they line up with it.
    always_comb begin
        mem_we_d     = (next_state == WR);
        resp_valid_d = (next_state == RESP);
        mem_addr_d   = mem_addr;
        mem_wd_d     = mem_wd;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        if (fire && !req_err) begin
            mem_addr_d = {req_addr[31:2], 2'b00};
        end
        if ((state == IDLE) && (next_state == WR)) begin
            mem_wd_d = req_wdata;
        end
        if ((state == WAIT) && (next_state == WR)) begin
            mem_wd_d = merged;
        end
        if ((state != RESP) && (next_state == RESP)) begin
            resp_err_d   = (state == IDLE);
            resp_rdata_d = (state == WAIT) ? load_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (fire) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                wdata_q   <= req_wdata[15:0];
            end
            if (state == RD) begin
                cnt_q <= 2'(RD_LATENCY - 1);
            end else if ((state == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 2'd1;
            end
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wd     <= mem_wd_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule
